stage4_mem: RTL and testbench

- MEM stage of the five-stage integer pipeline. It sits directly downstream of the EX stage.
- It consumes the EX/MEM bundle (IR, ALU output, register B) and issues load/store transactions to data memory over a ready/valid-style handshake.
- It aligns, sign-extends and zero-extends load data, then registers the MEM/WB bundle for writeback.
- It stalls the upstream stages while a memory access is outstanding.

---
 rtl/pipeline_pkg.sv | 32 +++
 rtl/mem_load_align.sv | 34 +++
 rtl/stage4_mem.sv | 123 ++++++++++++
 tb/tb_stage4_mem.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared decode constants, MEM-stage FSM encoding and exception codes for the
// integer pipeline.
package pipeline_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_BUS      = 2'b10;

  // Natural alignment check for the access size encoded in funct3.
  function automatic logic is_aligned(input logic [2:0] funct3, input logic [1:0] addr);
    case (funct3)
      F3_H, F3_HU: return ~addr[0];
      F3_W:        return (addr == 2'b00);
      default:     return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load-data lane select and sign/zero extension for byte, halfword and word loads.
module mem_load_align
  import pipeline_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] lmd
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (addr)
      2'b00:   byte_lane = rdata[7:0];
      2'b01:   byte_lane = rdata[15:8];
      2'b10:   byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
    half_lane = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    case (funct3)
      F3_B:    lmd = {{24{byte_lane[7]}}, byte_lane};
      F3_BU:   lmd = {24'h0, byte_lane};
      F3_H:    lmd = {{16{half_lane[15]}}, half_lane};
      F3_HU:   lmd = {16'h0, half_lane};
      default: lmd = rdata;
    endcase
  end

endmodule

// File: rtl/stage4_mem.sv
// MEM stage: issues data-memory loads/stores, aligns load data, stalls upstream
// while an access is outstanding and registers the MEM/WB bundle.
module stage4_mem
  import pipeline_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_mem_valid,
  input  logic [XLEN-1:0] ex_mem_ir,
  input  logic [XLEN-1:0] ex_mem_alu,
  input  logic [XLEN-1:0] ex_mem_b,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            stall,
  output logic            mem_wb_valid,
  output logic [XLEN-1:0] mem_wb_ir,
  output logic [XLEN-1:0] mem_wb_alu,
  output logic [XLEN-1:0] mem_wb_lmd,
  output logic [1:0]      mem_wb_exc,
  output logic [XLEN-1:0] mem_fwd,
  output mem_state_t      fsm_state
);

  mem_state_t  state_q;
  logic [15:0] wait_cnt;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_load;
  logic        is_store;
  logic        mem_op;
  logic        aligned;
  logic        timeout_hit;
  logic        retire;
  logic [31:0] lmd_ext;

  assign opcode   = ex_mem_ir[6:0];
  assign funct3   = ex_mem_ir[14:12];
  assign is_load  = (opcode == OP_LOAD) && (funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  assign is_store = (opcode == OP_STORE) && (funct3 inside {F3_B, F3_H, F3_W});
  assign mem_op   = is_load | is_store;
  assign aligned  = is_aligned(funct3, ex_mem_alu[1:0]);

  // The hit cycle is the last WAIT cycle; a ready arriving in it still wins.
  assign timeout_hit = (TIMEOUT != 0) && (state_q == WAIT) && !dmem_ready &&
                       (wait_cnt == 16'(TIMEOUT - 1));

  // Handshake: the request is held stable (inputs frozen by stall) until the
  // first cycle with dmem_ready=1, which both accepts and completes it; a
  // timeout or reset withdraws the request without completion.
  assign dmem_req  = reset & ex_mem_valid & mem_op & aligned & ~timeout_hit;
  assign dmem_we   = dmem_req & is_store;
  assign dmem_addr = {ex_mem_alu[31:2], 2'b00};
  assign stall     = dmem_req & ~dmem_ready & ~timeout_hit;
  assign retire    = ex_mem_valid & ~stall;
  assign fsm_state = state_q;

  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = ex_mem_b;
    case (funct3[1:0])
      2'b00: begin
        dmem_be    = 4'b0001 << ex_mem_alu[1:0];
        dmem_wdata = {4{ex_mem_b[7:0]}};
      end
      2'b01: begin
        dmem_be    = 4'b0011 << ex_mem_alu[1:0];
        dmem_wdata = {2{ex_mem_b[15:0]}};
      end
      default: ;
    endcase
  end

  mem_load_align u_align (
    .rdata  (dmem_rdata),
    .addr   (ex_mem_alu[1:0]),
    .funct3 (funct3),
    .lmd    (lmd_ext)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      wait_cnt <= '0;
    end else begin
      state_q  <= stall ? WAIT : IDLE;
      wait_cnt <= (state_q == WAIT && stall) ? wait_cnt + 16'd1 : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_wb_valid <= 1'b0;
      mem_wb_ir    <= '0;
      mem_wb_alu   <= '0;
      mem_wb_lmd   <= '0;
      mem_wb_exc   <= EXC_NONE;
    end else begin
      mem_wb_valid <= retire;
      if (retire) begin
        mem_wb_ir  <= ex_mem_ir;
        mem_wb_alu <= ex_mem_alu;
        mem_wb_lmd <= (is_load && dmem_req && dmem_ready) ? lmd_ext : '0;
        if (mem_op && !aligned)
          mem_wb_exc <= EXC_MISALIGN;
        else if (timeout_hit)
          mem_wb_exc <= EXC_BUS;
        else
          mem_wb_exc <= EXC_NONE;
      end
    end
  end

  assign mem_fwd = (mem_wb_ir[6:0] == OP_LOAD) ? mem_wb_lmd : mem_wb_alu;

endmodule

// File: tb/tb_stage4_mem.sv
// Self-checking bench for stage4_mem: directed scenarios plus randomized traffic
// against a behavioural model of the MEM stage.
module tb_stage4_mem;
  import pipeline_pkg::*;

  localparam int T = 4;
  localparam logic [6:0] OP_ADD = 7'b0110011;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_mem_valid;
  logic [31:0] ex_mem_ir, ex_mem_alu, ex_mem_b;
  logic        dmem_req, dmem_we, dmem_ready, stall;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        mem_wb_valid;
  logic [31:0] mem_wb_ir, mem_wb_alu, mem_wb_lmd, mem_fwd;
  logic [1:0]  mem_wb_exc;
  mem_state_t  fsm_state;

  int total = 0;
  int bad   = 0;

  stage4_mem #(.TIMEOUT(T), .XLEN(32)) dut (
    .clk(clk), .reset(reset), .ex_mem_valid(ex_mem_valid), .ex_mem_ir(ex_mem_ir),
    .ex_mem_alu(ex_mem_alu), .ex_mem_b(ex_mem_b), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .stall(stall),
    .mem_wb_valid(mem_wb_valid), .mem_wb_ir(mem_wb_ir), .mem_wb_alu(mem_wb_alu),
    .mem_wb_lmd(mem_wb_lmd), .mem_wb_exc(mem_wb_exc), .mem_fwd(mem_fwd),
    .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_ir(input logic [6:0] opc, input logic [2:0] f3);
    return {17'($urandom()), f3, 5'($urandom()), opc};
  endfunction

  // Behavioural model: access size in bytes, byte offset, shifts and masks.
  function automatic void model(input logic [31:0] ir, alu, b, rdata,
                                output logic is_ld, output logic is_st, output logic misal,
                                output logic [3:0] be, output logic [31:0] wdata,
                                output logic [31:0] lmd);
    logic [2:0]  f3;
    int          size, off;
    logic [31:0] mask, raw;
    f3    = ir[14:12];
    is_ld = (ir[6:0] == 7'b0000011) && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    is_st = (ir[6:0] == 7'b0100011) && (f3 <= 3'd2);
    size  = 1 << f3[1:0];
    off   = int'(alu[1:0]);
    misal = (is_ld || is_st) && (off % size != 0);
    be    = 4'(((1 << size) - 1) << off);
    case (size)
      1:       wdata = {24'h0, b[7:0]} * 32'h0101_0101;
      2:       wdata = {16'h0, b[15:0]} * 32'h0001_0001;
      default: wdata = b;
    endcase
    mask = (size == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * size)) - 32'd1;
    raw  = (rdata >> (8 * off)) & mask;
    if (!f3[2] && size < 4 && raw[8 * size - 1]) raw = raw | ~mask;
    lmd = raw;
  endfunction

  // driver: one instruction, memory answers after `waits` cycles (never if > T)
  task automatic run_op(input string tag, input logic [31:0] ir, alu, b, rdata, input int waits);
    logic        is_ld, is_st, misal, issue, timed_out;
    logic [3:0]  be;
    logic [31:0] wdata, lmd, exp_lmd, exp_fwd;
    logic [1:0]  exp_exc;
    int          done;
    logic        exp_req;
    model(ir, alu, b, rdata, is_ld, is_st, misal, be, wdata, lmd);
    issue     = (is_ld || is_st) && !misal;
    timed_out = issue && (waits > T);
    done      = !issue ? 0 : (timed_out ? T : waits);
    exp_lmd   = (is_ld && issue && !timed_out) ? lmd : 32'h0;
    exp_exc   = misal ? 2'b01 : (timed_out ? 2'b10 : 2'b00);
    exp_fwd   = (ir[6:0] == 7'b0000011) ? exp_lmd : alu;
    for (int c = 0; c <= done; c++) begin
      ex_mem_valid = 1'b1;
      ex_mem_ir    = ir;
      ex_mem_alu   = alu;
      ex_mem_b     = b;
      dmem_ready   = (c == waits);
      dmem_rdata   = (c == waits) ? rdata : $urandom();
      @(negedge clk);
      exp_req = issue && !(timed_out && c == T);
      check({tag, ".req"}, 32'(dmem_req), 32'(exp_req));
      check({tag, ".stall"}, 32'(stall), 32'(issue && c < done));
      if (exp_req) begin
        check({tag, ".we"}, 32'(dmem_we), 32'(is_st));
        check({tag, ".addr"}, dmem_addr, alu & 32'hFFFF_FFFC);
        check({tag, ".be"}, 32'(dmem_be), 32'(be));
        if (is_st) check({tag, ".wdata"}, dmem_wdata, wdata);
      end
      @(posedge clk);
      #1;
      if (c < done) begin
        check({tag, ".bubble"}, 32'(mem_wb_valid), 32'd0);
        check({tag, ".st_wait"}, 32'(fsm_state), 32'(WAIT));
      end else begin
        check({tag, ".valid"}, 32'(mem_wb_valid), 32'd1);
        check({tag, ".ir"}, mem_wb_ir, ir);
        check({tag, ".alu"}, mem_wb_alu, alu);
        check({tag, ".lmd"}, mem_wb_lmd, exp_lmd);
        check({tag, ".exc"}, 32'(mem_wb_exc), 32'(exp_exc));
        check({tag, ".fwd"}, mem_fwd, exp_fwd);
        check({tag, ".st_idle"}, 32'(fsm_state), 32'(IDLE));
      end
    end
  endtask

  task automatic idle_cycle(input string tag);
    ex_mem_valid = 1'b0;
    ex_mem_ir    = mk_ir(OP_LOAD, F3_W);
    ex_mem_alu   = $urandom();
    dmem_ready   = 1'($urandom());
    @(negedge clk);
    check({tag, ".req"}, 32'(dmem_req), 32'd0);
    check({tag, ".stall"}, 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    check({tag, ".valid"}, 32'(mem_wb_valid), 32'd0);
  endtask

  initial begin
    logic [2:0]  f3s_ld [5] = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [31:0] addr;
    reset = 1'b0; ex_mem_valid = 1'b0; ex_mem_ir = '0; ex_mem_alu = '0; ex_mem_b = '0;
    dmem_ready = 1'b0; dmem_rdata = '0;
    #2;
    check("rst.valid", 32'(mem_wb_valid), 32'd0);
    check("rst.ir", mem_wb_ir, 32'd0);
    check("rst.req", 32'(dmem_req), 32'd0);
    check("rst.stall", 32'(stall), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // directed scenarios
    run_op("sw0", {17'h0, F3_W, 5'd0, OP_STORE}, 32'h100, 32'hDEAD_BEEF, 32'h0, 0);
    run_op("lb3", {17'h0, F3_B, 5'd1, OP_LOAD}, 32'h103, 32'h0, 32'h8012_3456, 3);
    check("lb3.lmd_const", mem_wb_lmd, 32'hFFFF_FF80);
    run_op("lbu3", {17'h0, F3_BU, 5'd1, OP_LOAD}, 32'h103, 32'h0, 32'h8012_3456, 3);
    check("lbu3.lmd_const", mem_wb_lmd, 32'h0000_0080);
    run_op("sh", {17'h0, F3_H, 5'd0, OP_STORE}, 32'h202, 32'h1234_ABCD, 32'h0, 0);
    run_op("lh_mis", {17'h0, F3_H, 5'd2, OP_LOAD}, 32'h201, 32'h0, 32'h5555_5555, 0);
    run_op("lw_to", {17'h0, F3_W, 5'd3, OP_LOAD}, 32'h300, 32'h0, 32'h1111_1111, 50);
    check("lw_to.exc_const", 32'(mem_wb_exc), 32'h2);
    run_op("after_to", {17'h0, F3_W, 5'd3, OP_LOAD}, 32'h304, 32'h0, 32'hCAFE_F00D, 1);
    run_op("b2b_lw", {17'h0, F3_W, 5'd4, OP_LOAD}, 32'h400, 32'h0, 32'h7654_3210, 0);
    run_op("b2b_add", {17'h0, 3'b000, 5'd5, OP_ADD}, 32'h0000_1234, 32'h9, 32'h0, 0);
    run_op("b2b_sb", {17'h0, F3_B, 5'd0, OP_STORE}, 32'h401, 32'h0000_00A5, 32'h0, 0);
    idle_cycle("b2b_idle");

    // reset while in WAIT
    ex_mem_valid = 1'b1; ex_mem_ir = {17'h0, F3_W, 5'd6, OP_LOAD}; ex_mem_alu = 32'h500;
    dmem_ready = 1'b0;
    @(posedge clk); #1;
    check("rstw.in_wait", 32'(fsm_state), 32'(WAIT));
    #3 reset = 1'b0;
    #1;
    check("rstw.req", 32'(dmem_req), 32'd0);
    check("rstw.stall", 32'(stall), 32'd0);
    check("rstw.valid", 32'(mem_wb_valid), 32'd0);
    check("rstw.ir", mem_wb_ir, 32'd0);
    check("rstw.alu", mem_wb_alu, 32'd0);
    check("rstw.lmd", mem_wb_lmd, 32'd0);
    check("rstw.exc", 32'(mem_wb_exc), 32'd0);
    check("rstw.fwd", mem_fwd, 32'd0);
    check("rstw.state", 32'(fsm_state), 32'(IDLE));
    ex_mem_valid = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    run_op("rstw.add", {17'h0, 3'b000, 5'd7, OP_ADD}, 32'h0BAD_CAFE, 32'h1, 32'h0, 0);

    // randomized traffic
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 3))
        0: begin opc = OP_LOAD;  f3 = f3s_ld[$urandom_range(0, 4)]; end
        1: begin opc = OP_STORE; f3 = 3'($urandom_range(0, 2)); end
        2: begin opc = OP_ADD;   f3 = 3'($urandom()); end
        default: begin opc = OP_LOAD; f3 = F3_W; end
      endcase
      addr = $urandom();
      if ($urandom_range(0, 3) != 0) addr[1:0] = (f3[1:0] == 2'b10) ? 2'b00 :
                                                 (f3[1:0] == 2'b01) ? {1'($urandom()), 1'b0} : addr[1:0];
      if ($urandom_range(0, 7) == 0) idle_cycle("rnd_idle");
      run_op("rnd", mk_ir(opc, f3), addr, $urandom(), $urandom(),
             ($urandom_range(0, 9) == 0) ? $urandom_range(5, 8) : $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
